// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default geometry and FSM encodings.
package mem_pkg;

  localparam int MEM_AW = 12;
  localparam int MEM_DW = 16;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    SERVE = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_ram_1rw.sv
// Single-port RAM with one-cycle registered read; a write returns the new data (write-first).
module sync_ram_1rw
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Storage update and registered read; storage carries no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing memory responder: clears RAM after reset, serves CPU reads/writes,
// and hands the RAM to an external loader while LOAD_EN is held.
module mem_responder
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [31:0]   addr,
  input  logic [DW-1:0] memDat,
  input  logic          memWrite,
  output logic [DW-1:0] MEMD,
  output logic          MEMRDY,
  input  logic          LOAD_EN,
  input  logic          LD_VALID,
  input  logic [AW-1:0] LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  output logic          BUS_ERR
);

  state_t        state;
  logic [AW-1:0] clrCnt;
  logic          inRange;
  logic          ramWe;
  logic [AW-1:0] ramAddr;
  logic [DW-1:0] ramWdata;
  logic [DW-1:0] ramRdata_p1;
  logic          vld_p1;

  // Any address bit above the RAM depth makes the CPU access out of range
  assign inRange = (addr[31:AW] == '0);

  // Select which agent owns the single RAM port this cycle
  always_comb begin
    ramWe    = 1'b0;
    ramAddr  = addr[AW-1:0];
    ramWdata = memDat;
    case (state)
      CLEAR: begin
        ramWe    = 1'b1;
        ramAddr  = clrCnt;
        ramWdata = '0;
      end
      LOAD: begin
        ramWe    = LD_VALID;
        ramAddr  = LD_ADDR;
        ramWdata = LD_DATA;
      end
      default: begin
        ramWe    = memWrite & inRange;
      end
    endcase
  end

  sync_ram_1rw #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk  (CLK),
    .we   (ramWe),
    .addr (ramAddr),
    .wdata(ramWdata),
    .rdata(ramRdata_p1)
  );

  // Mode sequencing with registered handshake outputs; vld_p1 marks a CPU read
  // whose data is legitimately on the RAM output this cycle
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= CLEAR;
      clrCnt   <= '0;
      MEMRDY   <= 1'b0;
      LD_READY <= 1'b0;
      BUS_ERR  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      BUS_ERR <= 1'b0;
      vld_p1  <= 1'b0;
      case (state)
        CLEAR: begin
          clrCnt <= clrCnt + 1'b1;
          if (clrCnt == '1) begin
            state  <= SERVE;
            MEMRDY <= 1'b1;
          end
        end
        SERVE: begin
          // The access at the hand-over edge still completes, but its read data
          // is suppressed so LOAD always presents MEMD=0
          if (LOAD_EN) begin
            state    <= LOAD;
            MEMRDY   <= 1'b0;
            LD_READY <= 1'b1;
          end else begin
            vld_p1  <= inRange;
            BUS_ERR <= ~inRange;
          end
        end
        LOAD: begin
          if (!LOAD_EN) begin
            state    <= SERVE;
            MEMRDY   <= 1'b1;
            LD_READY <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

  // Read data is gated so loader writes and out-of-range reads never leak out
  assign MEMD = vld_p1 ? ramRdata_p1 : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic compared each cycle against a behavioural model of the responder.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int AW    = 12;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [31:0]   addr = '0;
  logic [DW-1:0] memDat = '0;
  logic          memWrite = 1'b0;
  logic [DW-1:0] MEMD;
  logic          MEMRDY;
  logic          LOAD_EN = 1'b0;
  logic          LD_VALID = 1'b0;
  logic [AW-1:0] LD_ADDR = '0;
  logic [DW-1:0] LD_DATA = '0;
  logic          LD_READY;
  logic          BUS_ERR;

  always #5 CLK = ~CLK;

  mem_responder #(.AW(AW), .DW(DW)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .addr    (addr),
    .memDat  (memDat),
    .memWrite(memWrite),
    .MEMD    (MEMD),
    .MEMRDY  (MEMRDY),
    .LOAD_EN (LOAD_EN),
    .LD_VALID(LD_VALID),
    .LD_ADDR (LD_ADDR),
    .LD_DATA (LD_DATA),
    .LD_READY(LD_READY),
    .BUS_ERR (BUS_ERR)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = clearing, 1 = serving CPU, 2 = loader owns RAM
  logic [DW-1:0] ram [DEPTH];
  int            mMode  = 0;
  int            clrIdx = 0;
  bit            live   = 0;
  logic [DW-1:0] eMemd  = '0;
  logic          eRdy   = 1'b0;
  logic          eLdr   = 1'b0;
  logic          eErr   = 1'b0;

  always @(posedge CLK) begin
    bit inr;
    if (!RST_N) begin
      live   = 1;
      mMode  = 0;
      clrIdx = 0;
      eMemd  = '0;
      eRdy   = 1'b0;
      eLdr   = 1'b0;
      eErr   = 1'b0;
    end else if (live) begin
      eMemd = '0;
      eErr  = 1'b0;
      if (mMode == 0) begin
        ram[clrIdx] = '0;
        clrIdx++;
        if (clrIdx == DEPTH) begin
          mMode = 1;
          eRdy  = 1'b1;
        end
      end else if (mMode == 1) begin
        inr = (addr < 32'(DEPTH));
        if (inr && memWrite) ram[addr[AW-1:0]] = memDat;
        if (LOAD_EN) begin
          mMode = 2;
          eRdy  = 1'b0;
          eLdr  = 1'b1;
        end else begin
          eErr  = ~inr;
          eMemd = inr ? ram[addr[AW-1:0]] : '0;
        end
      end else begin
        if (LD_VALID) ram[LD_ADDR] = LD_DATA;
        if (!LOAD_EN) begin
          mMode = 1;
          eRdy  = 1'b1;
          eLdr  = 1'b0;
        end
      end
    end
  end

  // Compare every output against the model once per cycle, away from the active edge
  always @(negedge CLK) begin
    if (live) begin
      chk("MEMD",     MEMD,     eMemd);
      chk("MEMRDY",   MEMRDY,   eRdy);
      chk("LD_READY", LD_READY, eLdr);
      chk("BUS_ERR",  BUS_ERR,  eErr);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idleInputs();
    addr     = '0;
    memDat   = '0;
    memWrite = 1'b0;
    LOAD_EN  = 1'b0;
    LD_VALID = 1'b0;
    LD_ADDR  = '0;
    LD_DATA  = '0;
  endtask

  task automatic randomTraffic(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = $urandom() | 32'h0000_1000;
      else if (r == 1) addr = 32'h0000_1000 + 32'($urandom_range(0, 15));
      else if (r == 2) addr = 32'(DEPTH - 1);
      else             addr = 32'($urandom_range(0, 31));
      memDat   = DW'($urandom());
      memWrite = 1'($urandom_range(0, 1));
      LD_VALID = 1'($urandom_range(0, 1));
      LD_ADDR  = AW'($urandom_range(0, 31));
      LD_DATA  = DW'($urandom());
      if ($urandom_range(0, 19) == 0) LOAD_EN = ~LOAD_EN;
      step(1);
    end
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_MEMRDY",   MEMRDY,   0);
    chk("rst_MEMD",     MEMD,     0);
    chk("rst_LD_READY", LD_READY, 0);
    chk("rst_BUS_ERR",  BUS_ERR,  0);

    // Clear sweep: 4096 edges after release, ready from the 4097th cycle
    RST_N = 1'b1;
    step(DEPTH - 1);
    chk("clr_rdy_early", MEMRDY, 0);
    step(1);
    chk("clr_rdy_rise", MEMRDY, 1);

    addr = 32'h0000_0FFF;
    step(1);
    chk("rd_fff", MEMD, 16'h0000);
    chk("rd_fff_err", BUS_ERR, 0);

    // Write then read back
    addr = 32'h0000_0010; memDat = 16'hBEEF; memWrite = 1'b1;
    step(1);
    memWrite = 1'b0;
    step(1);
    chk("rd_beef", MEMD, 16'hBEEF);

    // Same-edge read and write
    addr = 32'h0000_0020; memDat = 16'h1234; memWrite = 1'b1;
    step(1);
    chk("wfirst_1234", MEMD, 16'h1234);

    // Out-of-range write is dropped and flagged for one cycle
    addr = 32'h0001_0000; memDat = 16'hAAAA;
    step(1);
    chk("oor_err", BUS_ERR, 1);
    chk("oor_memd", MEMD, 0);
    memWrite = 1'b0; addr = 32'h0;
    step(1);
    chk("oor_err_end", BUS_ERR, 0);
    chk("rd_0_after_oor", MEMD, 16'h0000);

    // Loader session: CPU write to the same word is ignored
    LOAD_EN = 1'b1;
    step(1);
    chk("ld_rdy_low", MEMRDY, 0);
    chk("ld_ready", LD_READY, 1);
    LD_VALID = 1'b1; LD_ADDR = 12'd3; LD_DATA = 16'h5A5A;
    addr = 32'h3; memWrite = 1'b1; memDat = 16'h1111;
    step(1);
    chk("ld_rdy_still_low", MEMRDY, 0);
    chk("ld_memd_zero", MEMD, 0);
    LD_VALID = 1'b0; memWrite = 1'b0; LOAD_EN = 1'b0;
    step(1);
    chk("ld_exit_rdy", MEMRDY, 1);
    chk("ld_exit_ready", LD_READY, 0);
    step(1);
    chk("rd_3_loaded", MEMD, 16'h5A5A);

    // Randomized mixed traffic
    randomTraffic(3000);
    idleInputs();
    step(2);

    // Reset during LOAD, then reset again partway through the clear
    LOAD_EN = 1'b1;
    step(2);
    RST_N = 1'b0;
    step(1);
    chk("rst_ld_MEMRDY", MEMRDY, 0);
    chk("rst_ld_LD_READY", LD_READY, 0);
    RST_N = 1'b1;
    step(100);
    RST_N = 1'b0;
    step(1);
    RST_N = 1'b1;
    // LOAD_EN is still held: it must wait for the clear to finish
    step(DEPTH - 1);
    chk("reclr_rdy_early", MEMRDY, 0);
    chk("reclr_no_ld", LD_READY, 0);
    step(1);
    chk("reclr_rdy_rise", MEMRDY, 1);
    chk("reclr_serve_first", LD_READY, 0);
    step(1);
    chk("reclr_to_load_rdy", MEMRDY, 0);
    chk("reclr_to_load_ready", LD_READY, 1);
    LOAD_EN = 1'b0;
    step(1);
    chk("reclr_back_serve", MEMRDY, 1);

    randomTraffic(800);
    idleInputs();
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
